// File: rtl/minmax_stream_ctrl.sv
// Streaming min/max reducer: LANES-wide combinational reduction per beat, registered running
// best across up to BEATS beats, one registered result per frame behind a valid/ready handshake.
module minmax_stream_ctrl #(
  parameter int unsigned W     = 5,
  parameter int unsigned LANES = 4,
  parameter int unsigned BEATS = 16,
  parameter int unsigned IDXW  = (LANES * BEATS > 1) ? $clog2(LANES * BEATS) : 1,
  parameter int unsigned BCW   = $clog2(BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_us_sel,
  input  logic                 cfg_min_max_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_result,
  output logic [IDXW-1:0]      out_index,
  output logic [BCW-1:0]       out_beats
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e          state_q;
  logic            cfg_us_q;
  logic            cfg_mm_q;
  logic [BCW-1:0]  count_q;
  logic [W-1:0]    best_q;
  logic [IDXW-1:0] best_idx_q;
  logic            out_valid_q;

  logic            first_beat;
  logic            eff_us;
  logic            eff_mm;
  logic            accept;
  logic            final_beat;
  logic [BCW-1:0]  beat_num;
  logic [W-1:0]    win_val;
  logic [LW-1:0]   win_lane;
  logic [IDXW-1:0] win_idx;

  // Strict "a beats b" under the selected ordering; sign or zero extension by one bit.
  function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sgn, input logic mx);
    logic signed [W:0] ea;
    logic signed [W:0] eb;
    ea = {sgn & a[W-1], a};
    eb = {sgn & b[W-1], b};
    return mx ? (ea > eb) : (ea < eb);
  endfunction

  // Any beat accepted outside ACC opens a new frame, including the DONE bypass.
  assign first_beat = (state_q != StAcc);
  assign eff_us     = first_beat ? cfg_us_sel : cfg_us_q;
  assign eff_mm     = first_beat ? cfg_min_max_sel : cfg_mm_q;
  assign in_ready   = !rst && ((state_q != StDone) || out_ready);
  assign accept     = in_valid && in_ready;
  assign beat_num   = first_beat ? '0 : count_q;
  assign final_beat = in_last || ((32'(beat_num) + 32'd1) == BEATS);

  // Scanning upward with a strict compare keeps the lowest lane on ties.
  always_comb begin
    win_val  = in_data[W-1:0];
    win_lane = '0;
    for (int k = 1; k < int'(LANES); k++) begin
      if (better(in_data[W*k +: W], win_val, eff_us, eff_mm)) begin
        win_val  = in_data[W*k +: W];
        win_lane = LW'(k);
      end
    end
  end

  assign win_idx = IDXW'(32'(beat_num) * LANES + 32'(win_lane));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cfg_us_q    <= 1'b0;
      cfg_mm_q    <= 1'b0;
      count_q     <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      if (first_beat) begin
        cfg_us_q   <= cfg_us_sel;
        cfg_mm_q   <= cfg_min_max_sel;
        best_q     <= win_val;
        best_idx_q <= win_idx;
        count_q    <= BCW'(1);
      end else begin
        if (better(win_val, best_q, cfg_us_q, cfg_mm_q)) begin
          best_q     <= win_val;
          best_idx_q <= win_idx;
        end
        count_q <= count_q + BCW'(1);
      end
      state_q     <= final_beat ? StDone : StAcc;
      out_valid_q <= final_beat;
    end else if ((state_q == StDone) && out_ready) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = best_q;
  assign out_index  = best_idx_q;
  assign out_beats  = count_q;

endmodule

// File: doc/minmax_stream_ctrl.md
Name: minmax_stream_ctrl

Overview:
Sequencing controller that reduces a streamed frame of W-bit elements to a single min or max value and its global element index. Each beat carries LANES elements; a combinational LANES-wide min/max reduction is applied per beat, and a registered running best is kept across beats. The block sits between an upstream valid/ready producer and a downstream valid/ready result consumer, and time-shares one narrow comparator tree over frames much wider than the tree.

Parameters:
W, 5, element width in bits
LANES, 4, elements per input beat (>=1)
BEATS, 16, maximum beats per frame (>=1)
IDXW, $clog2(LANES*BEATS), global index width (minimum 1)
BCW, $clog2(BEATS+1), beat-count width

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
cfg_us_sel  input  1  0=unsigned compare, 1=signed (two's complement); sampled on the frame's first beat
cfg_min_max_sel  input  1  0=min, 1=max; sampled on the frame's first beat
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid&&in_ready
in_data  input  LANES*W  lane k = in_data[W*(k+1)-1:W*k]
in_last  input  1  marks the final beat of a short frame
out_valid  output  1  result valid
out_ready  input  1  result accepted when out_valid&&out_ready
out_result  output  W  best element of the frame
out_index  output  IDXW  global index = beat*LANES + lane
out_beats  output  BCW  number of beats in the frame (1..BEATS)

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0, out_result=0, out_index=0, out_beats=0; beat counter=0; latched cfg=0. in_ready=0 while rst is high.
- FSM states: IDLE, ACC, DONE.
  - IDLE: in_ready=1. An accepted beat latches cfg_us_sel/cfg_min_max_sel, seeds the running best with the beat's winner, and sets beat count=1. Next state: DONE if the beat is final, else ACC.
  - ACC: in_ready=1. Each accepted beat updates the running best and increments the count. Next state is DONE on the final beat. No state change without an accepted beat.
  - DONE: out_valid=1; outputs are stable until the handshake. in_ready=out_ready (one-cycle bypass). On out_valid&&out_ready: if a beat is accepted the same cycle, it starts a new frame (IDLE-accept semantics, next state ACC or DONE); otherwise next state is IDLE.
- Final beat: in_last=1, OR count reaches BEATS on this beat. in_last is ignored except on accepted beats.
- Per-beat reduction (combinational): strict compare using the latched cfg (or live cfg on the first beat). On equal values the lowest lane wins.
- Running update: replace the best only if the beat winner is strictly better. Across beats, equal values keep the earlier index. Net rule: ties resolve to the lowest global index.
- Latency: out_valid rises on the cycle after the final beat is accepted. out_result, out_index and out_beats are registered and valid at the same time.
- Throughput: 1 beat/cycle; back-to-back frames with zero bubble when out_ready=1.
- cfg changes after the first beat of a frame have no effect until the next frame.
- Signed compare: sign-extend W-bit values. Unsigned compare: zero-extend. Index arithmetic: beat count*LANES + lane, in IDXW bits; never overflows by construction.
- Reset mid-frame discards the partial frame. The next frame starts at index 0.
- in_valid=0 in any state: no state or output change.

Test Plan:
Unsigned min, BEATS=4, LANES=4, beats {7,3,9,3},{5,2,8,2},{31,30,2,1},{4,4,4,4} (lane0 first) -> out_result=1, out_index=11, out_beats=4, out_valid exactly 1 cycle after the 4th accept.
Same data with cfg max+unsigned -> result 31, index 8. Same data with cfg max+signed -> result 9, index 2 (31/30 read as -1/-2).
Ties: all 16 elements=10, min -> result 10, index 0. Repeat with max -> result 10, index 0.
Short frame: in_last on beat 1 (second beat), data {6,6,6,6},{6,6,6,5}, min -> result 5, index 7, out_beats=2. A subsequent full frame starts indices at 0.
Backpressure/bypass: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 -> beat accepted as frame 2 beat 0, out_valid=0 next cycle (or 1 if BEATS=1). Toggle cfg mid-frame -> frame result follows the first-beat cfg.
Reset mid-frame: assert rst after 2 of 4 beats -> out_valid=0 and outputs=0 immediately. After release, a new 4-beat frame {1,1,1,1}x4 min -> result 1, index 0, out_beats=4.
